dsp_mac_ctrl: RTL and testbench

Sequencer that drives a fully registered DSP slice as a dot-product engine: it accepts `len` operand pairs over a valid/ready stream and steers the slice's A/B inputs and OPMODE. It returns the 48-bit sum of products once the slice pipeline has drained. It sits between a sample source (FIR tap/coefficient fetch) and one DSP slice configured with A0REG=A1REG=B0REG=B1REG=MREG=PREG=1, B_INPUT=1 and CARRYIN unused.

---
 rtl/dsp_mac_ctrl_pkg.sv | 17 +
 rtl/dsp_mac_ctrl.sv | 136 +++++++++++++
 tb/tb_dsp_mac_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_ctrl_pkg.sv
// Shared constants and types for the DSP dot-product sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dsp_mac_ctrl_pkg;

  // OPMODE encodings for the DSP slice: X[1:0]=M, Z[3:2]=0 or P, post-adder adds.
  localparam logic [7:0] OPM_MAC_FIRST = 8'h01;  // P <= M       (start of a new sum)
  localparam logic [7:0] OPM_MAC_ACC   = 8'h09;  // P <= P + M   (accumulate)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dsp_mac_ctrl.sv
// Sequences one fully registered DSP slice as a len-term dot-product engine.
// Latency: last operand handshake to result_valid = PIPE_LAT+1 cycles; len=0 gives result 2 cycles after start.
// Backpressure: in_ready is high for the whole FEED phase; idle input cycles push a harmless 0*0 term.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   start, len, busy         run control; start is ignored while busy
//   in_valid/in_ready, in_a, in_b   signed operand stream
//   dsp_a, dsp_b, dsp_opmode, dsp_ce, dsp_rst, dsp_p   DSP slice interface
//   result, result_valid     final sum (held) and one-cycle completion pulse
module dsp_mac_ctrl
  import dsp_mac_ctrl_pkg::*;
#(
  parameter int width_one   = 18,
  parameter int width_three = 48,
  parameter int LEN_W       = 8,
  parameter int PIPE_LAT    = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        start,
  input  logic [LEN_W-1:0]            len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [width_one-1:0] in_a,
  input  logic signed [width_one-1:0] in_b,
  output logic [width_one-1:0]        dsp_a,
  output logic [width_one-1:0]        dsp_b,
  output logic [7:0]                  dsp_opmode,
  output logic                        dsp_ce,
  output logic                        dsp_rst,
  input  logic [width_three-1:0]      dsp_p,
  output logic                        busy,
  output logic [width_three-1:0]      result,
  output logic                        result_valid
);

  // Depth from the slice input to the M register; the first-term tag rides alongside.
  localparam int TAG_D = PIPE_LAT - 1;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic             hs;
  logic             first_pend;   // next handshake is the first term of this run
  logic             zero_run;     // current run was started with len=0
  logic [TAG_D-1:0] tag_sr;

  assign dsp_ce  = 1'b1;
  assign dsp_rst = RST;

  // The tag arrives at the end of the shift register in the same cycle the
  // first product sits in M, so P is overwritten rather than accumulated.
  assign dsp_opmode = tag_sr[TAG_D-1] ? OPM_MAC_FIRST : OPM_MAC_ACC;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    hs        = 1'b0;
    dsp_a     = '0;
    dsp_b     = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_nxt = FEED;
            cnt_nxt   = len;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      FEED: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hs    = 1'b1;
          dsp_a = in_a;
          dsp_b = in_b;
          if (cnt == LEN_W'(1)) begin
            // Counter is reused to time the drain of the slice pipeline.
            state_nxt = DRAIN;
            cnt_nxt   = LEN_W'(PIPE_LAT - 1);
          end else begin
            cnt_nxt = cnt - LEN_W'(1);
          end
        end
      end
      DRAIN: begin
        cnt_nxt = cnt - LEN_W'(1);
        if (cnt == LEN_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      cnt          <= '0;
      first_pend   <= 1'b0;
      zero_run     <= 1'b0;
      tag_sr       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      result_valid <= (state == DONE);

      if (state == IDLE && start) begin
        first_pend <= (len != '0);
        zero_run   <= (len == '0);
      end else if (hs) begin
        first_pend <= 1'b0;
      end

      tag_sr[0] <= hs & first_pend;
      for (int i = 1; i < TAG_D; i++) begin
        tag_sr[i] <= tag_sr[i-1];
      end

      if (state == DONE) begin
        result <= zero_run ? '0 : dsp_p;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// Directed bench for dsp_mac_ctrl driving a behavioural DSP slice (A0/A1/B0/B1/M/P registered).
// Latency: checks exact cycle of OPMODE first-term and of result_valid for every run.
// Backpressure: exercises gaps in in_valid and start pulses while busy.
module tb_dsp_mac_ctrl;

  localparam int PIPE_LAT = 4;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               start = 1'b0;
  logic [7:0]         len = 8'd0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [17:0] in_a = '0;
  logic signed [17:0] in_b = '0;
  logic [17:0]        dsp_a, dsp_b;
  logic [7:0]         dsp_opmode;
  logic               dsp_ce, dsp_rst;
  logic [47:0]        dsp_p;
  logic               busy;
  logic [47:0]        result;
  logic               result_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int opm_hits = 0;
  int opm_cyc  = -1;
  int rv_cnt   = 0;

  logic signed [17:0] ta [8];
  logic signed [17:0] tbv [8];

  always #5 CLK = ~CLK;

  dsp_mac_ctrl #(
    .width_one(18), .width_three(48), .LEN_W(8), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
    .dsp_rst(dsp_rst), .dsp_p(dsp_p), .busy(busy), .result(result),
    .result_valid(result_valid)
  );

  // Behavioural DSP slice: X = OPMODE[1:0] (01 -> M), Z = OPMODE[3:2] (10 -> P).
  logic signed [17:0] sa0, sa1, sb0, sb1;
  logic signed [35:0] sm;
  logic [47:0]        sp, xmux, zmux;

  always_comb begin
    xmux = (dsp_opmode[1:0] == 2'b01) ? {{12{sm[35]}}, sm} : 48'd0;
    zmux = (dsp_opmode[3:2] == 2'b10) ? sp : 48'd0;
  end

  always_ff @(posedge CLK) begin
    if (dsp_rst) begin
      sa0 <= '0; sa1 <= '0; sb0 <= '0; sb1 <= '0; sm <= '0; sp <= '0;
    end else if (dsp_ce) begin
      sa0 <= dsp_a; sa1 <= sa0;
      sb0 <= dsp_b; sb1 <= sb0;
      sm  <= sa1 * sb1;
      sp  <= zmux + xmux;
    end
  end
  assign dsp_p = sp;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (dsp_opmode == 8'h01) begin
      opm_hits = opm_hits + 1;
      opm_cyc  = cyc;
    end
    if (result_valid) rv_cnt = rv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One dot product of n terms from ta/tbv; in_valid is held low for gap_len
  // cycles before term gap_at. With poke set, start is pulsed during the gap.
  // Returns in the result_valid cycle.
  task automatic run(input int n, input int gap_at, input int gap_len, input bit poke,
                     input logic [47:0] exp, input string tag);
    int k, g, budget, c0, cl, hits0;
    hits0 = opm_hits;
    start = 1'b1;
    len   = n[7:0];
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    k = 0; g = 0; budget = 0; c0 = -1; cl = -1;
    while (k < n && budget < 64) begin
      if (k == gap_at && g < gap_len) begin
        in_valid = 1'b0;
        g++;
        if (poke) begin
          start = 1'b1;
          len   = 8'd5;
        end
        chk({tag, "_gap_rdy"}, 64'(in_ready), 64'd1);
      end else begin
        start    = 1'b0;
        in_valid = 1'b1;
        in_a     = ta[k];
        in_b     = tbv[k];
        if (in_ready) begin
          if (k == 0) c0 = cyc;
          cl = cyc;
          k++;
        end
      end
      tick();
      budget++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk({tag, "_fed"}, 64'(k), 64'(n));
    chk({tag, "_rdy_drop"}, 64'(in_ready), 64'd0);
    budget = 0;
    while (!result_valid && budget < 20) begin
      tick();
      budget++;
    end
    chk({tag, "_rv"}, 64'(result_valid), 64'd1);
    chk({tag, "_lat"}, 64'(cyc), 64'(cl + PIPE_LAT + 1));
    chk({tag, "_res"}, 64'(result), 64'(exp));
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_opm_cyc"}, 64'(opm_cyc), 64'(c0 + PIPE_LAT - 1));
    chk({tag, "_opm_once"}, 64'(opm_hits - hits0), 64'd1);
  endtask

  initial begin : main
    int rv0;
    // Reset state
    RST = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd0);
    chk("rst_rv", 64'(result_valid), 64'd0);
    chk("rst_res", 64'(result), 64'd0);
    chk("rst_a", 64'(dsp_a), 64'd0);
    chk("rst_b", 64'(dsp_b), 64'd0);
    chk("rst_opm", 64'(dsp_opmode), 64'h09);
    chk("rst_dsprst", 64'(dsp_rst), 64'd1);
    chk("rst_ce", 64'(dsp_ce), 64'd1);
    RST = 1'b0;
    tick();
    chk("run_dsprst", 64'(dsp_rst), 64'd0);

    // len=3 back-to-back: 6 - 20 + 7 = -7
    ta[0] = 18'sd2;  tbv[0] = 18'sd3;
    ta[1] = -18'sd4; tbv[1] = 18'sd5;
    ta[2] = 18'sd7;  tbv[2] = 18'sd1;
    run(3, 99, 0, 1'b0, 48'hFFFF_FFFF_FFF9, "neg");
    tick();
    chk("pulse_once", 64'(result_valid), 64'd0);
    chk("res_hold", 64'(result), 64'hFFFF_FFFF_FFF9);

    // len=4 with a 2-cycle in_valid gap after term 2: 4 * 10000
    for (int i = 0; i < 4; i++) begin
      ta[i] = 18'sd100; tbv[i] = 18'sd100;
    end
    run(4, 2, 2, 1'b0, 48'd40000, "gap");

    // Two consecutive runs; the second starts in the result_valid cycle
    tick();
    ta[0] = 18'sd1; tbv[0] = 18'sd1;
    ta[1] = 18'sd1; tbv[1] = 18'sd1;
    run(2, 99, 0, 1'b0, 48'd2, "seq1");
    ta[0] = 18'sd3; tbv[0] = 18'sd3;
    run(1, 99, 0, 1'b0, 48'd9, "seq2");

    // len=0: forced zero result two cycles after start
    tick();
    start = 1'b1;
    len   = 8'd0;
    tick();
    start = 1'b0;
    chk("len0_busy", 64'(busy), 64'd1);
    tick();
    chk("len0_rv", 64'(result_valid), 64'd1);
    chk("len0_res", 64'(result), 64'd0);
    tick();
    chk("len0_pulse", 64'(result_valid), 64'd0);

    // start pulsed while busy is ignored: (1*2)+(3*4) = 14
    ta[0] = 18'sd1; tbv[0] = 18'sd2;
    ta[1] = 18'sd3; tbv[1] = 18'sd4;
    run(2, 0, 1, 1'b1, 48'd14, "poke");
    tick();
    chk("poke_norestart", 64'(busy), 64'd0);

    // Extremes: 2 * (-131072)^2 = 2^35
    ta[0] = -18'sd131072; tbv[0] = -18'sd131072;
    ta[1] = -18'sd131072; tbv[1] = -18'sd131072;
    run(2, 99, 0, 1'b0, 48'h0008_0000_0000, "ext");

    // Reset during DRAIN aborts the run
    tick();
    start = 1'b1;
    len   = 8'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_a = 18'sd1;
    in_b = 18'sd1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("abort_drain_busy", 64'(busy), 64'd1);
    chk("abort_drain_rdy", 64'(in_ready), 64'd0);
    rv0 = rv_cnt;
    RST = 1'b1;
    #1;
    chk("abort_dsprst", 64'(dsp_rst), 64'd1);
    tick();
    RST = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rv", 64'(result_valid), 64'd0);
    chk("abort_res", 64'(result), 64'd0);
    repeat (8) tick();
    chk("abort_no_rv", 64'(rv_cnt), 64'(rv0));

    // Fresh run after the abort: 5 * 6 = 30
    ta[0] = 18'sd5; tbv[0] = 18'sd6;
    run(1, 99, 0, 1'b0, 48'd30, "post_abort");

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
